skew_feed_ctrl: RTL and testbench
=================================

# skew_feed_ctrl

Sequencing controller for the systolic-array input skew buffer. It accepts a burst of `vec_len` input vectors of `ROWS` lanes each through a valid/ready handshake. Lane r is pushed through an enabled-DFF delay line of depth r+1, and the controller drives one common shift enable to every delay line. At the array edge this produces the diagonal (wavefront) ordering the PE grid needs, then drains the buffer with zero fill and signals completion.

## Interface
- `ROWS`, 8: number of lanes / array rows (≥1)
- `DATA_WIDTH`, 8: bits per lane element
- `LEN_WIDTH`, 8: width of burst length
- `clk`  in  1  clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin burst; sampled only in IDLE
- `vec_len`  in  LEN_WIDTH  vectors in burst; sampled with `start`
- `in_valid`  in  1  input vector valid
- `in_ready`  out  1  controller accepts vector this cycle
- `in_data`  in  ROWS*DATA_WIDTH  lane r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- `out_data`  out  ROWS*DATA_WIDTH  last stage of each lane delay line
- `out_valid`  out  ROWS  per-lane valid bit at last stage
- `adv`  out  1  beat strobe: array consumes out_data/out_valid when high
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: `start`=1 latches `vec_len`. If `vec_len`=0, go to DONE. Otherwise go to STREAM and clear the beat counter.
- STREAM: `in_ready`=1. Accept = `in_valid & in_ready`.
  - Each accept shifts all lanes, loading `in_data` and valid=1 into stage 0 of each lane.
  - The accept that makes the count reach `vec_len` moves the FSM to DRAIN, or to DONE if ROWS=1.
  - `in_valid`=0 means no shift; all stages hold (stall).
- DRAIN: `in_ready`=0. Runs exactly ROWS-1 cycles, shifting every cycle with zero data and valid=0 into stage 0. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Shift enable `sh` = accept | (state==DRAIN). `sh` is the `en` of every stage in every lane.
- Lane r has r+1 stages. An element accepted at shift k appears at lane r's output after shift k+r.
- `adv` = `sh` registered by one cycle. A beat is any cycle with `adv`=1.
- `out_data` lane r is 0 whenever `out_valid[r]`=0. Stage data is zero-filled, so this holds by construction.
- Beat counter is LEN_WIDTH bits and never wraps: its maximum is `vec_len` ≤ 2^LEN_WIDTH−1.
- `start` outside IDLE is ignored. `vec_len` changes outside IDLE have no effect.

## Timing
- Reset values: all stage data 0, all valid bits 0, `in_ready`=0, `adv`=0, `busy`=0, `done`=0, FSM IDLE, counters 0.
- `start` in cycle t puts the FSM in STREAM at t+1, so `in_ready` is first high at t+1.
- Lane 0 of the vector accepted in cycle t is visible with `adv`=1 in cycle t+1. Lane r appears in the beat produced by the r-th subsequent shift.
- With no stalls, the burst occupies `vec_len`+ROWS−1 consecutive beats. Latency from the last accept to `done` is ROWS cycles.
  - `done` coincides with the final `adv` beat, which carries lane ROWS−1 of the last vector.
- A stall freezes all lanes and `out_valid`. `adv`=0 on the following cycle.
- `busy`=1 from the cycle after `start` through the DONE cycle, inclusive.
- `rst_n` asserted mid-burst: everything clears immediately. No `done` is issued, and in-flight data is discarded.
- `in_valid` held high in IDLE or DRAIN is not accepted; `in_ready`=0 in those states.

## Structure
- Shared package `tpu_pkg` holds:
  - the FSM state enum (IDLE/STREAM/DRAIN/DONE);
  - the default `DATA_WIDTH`;
  - a `clog2` helper for the drain counter width.
- Sub-module `skew_delay_line`: parameters DEPTH and DATA_WIDTH. It is a chain of enabled, async-reset DFFs carrying data plus a valid bit.
- The controller instantiates one `skew_delay_line` per lane via a generate loop, with DEPTH=r+1.

## Test plan
- ROWS=4, vec_len=3, `in_valid` constantly 1, vectors {lanes 0..3}: V0={1,2,3,4}, V1={5,6,7,8}, V2={9,10,11,12}.
  - Six consecutive beats. Lane 0 carries 1,5,9 on beats 1–3. Lane 3 carries 4,8,12 on beats 4–6.
  - `done` is on beat 6; `out_valid` is 0 elsewhere.
- Same burst with `in_valid` low for 2 cycles after V0. `adv` drops for 2 cycles and outputs hold. The beat sequence is otherwise identical.
- `start` with vec_len=0: `busy`=1 for one cycle with `done`=1 and no `adv`. `in_ready` never asserts.
- ROWS=1, vec_len=2: DRAIN is skipped. `done` is on the beat carrying the second element, 1 cycle after the final accept.
- Assert `rst_n`=0 during DRAIN of a vec_len=5 burst. All outputs are 0 at once, there is no `done`, and a fresh `start` behaves as after power-up.
- `start` pulsed during STREAM, and `in_valid` high while in DRAIN: both are ignored, and the accept count stays at `vec_len`.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types, defaults and helpers for the TPU input path.
package tpu_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;
    localparam int DEF_DATA_WIDTH = 8;
    // Never returns less than 1 so counters stay legal for tiny arrays.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: enabled DFF chain carrying data plus a valid bit.
module skew_delay_line
    import tpu_pkg::*;
#(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]                 vld_q, vld_d;
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (en) begin
            data_d[0] = in_data;
            vld_d[0]  = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end
    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
endmodule

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: accepts a vector burst and skews lane r by r+1 stages
// to form the systolic wavefront, then drains with zero fill.
module skew_feed_ctrl
    import tpu_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       vec_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic                       adv,
    output logic                       busy,
    output logic                       done
);
    localparam int CW = clog2(ROWS);
    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]        drn_q, drn_d;
    logic                 adv_q, acc, sh;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        acc     = (state_q == STREAM) && in_valid;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            IDLE: if (start) begin
                len_d   = vec_len;
                cnt_d   = '0;
                drn_d   = '0;
                state_d = (vec_len == '0) ? DONE : STREAM;
            end
            STREAM: if (acc) begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) state_d = (ROWS == 1) ? DONE : DRAIN;
            end
            DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (int'(drn_q) == ROWS - 2) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        sh = acc || (state_q == DRAIN);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            adv_q   <= sh;
        end
    end
    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign adv      = adv_q;
    // Drain shifts load zero data with valid low, keeping idle lanes at 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_dl (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (sh),
            .in_data   (acc ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0),
            .in_valid  (acc),
            .out_data  (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (out_valid[r])
        );
    end
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: ROWS=4 and ROWS=1 controllers checked against a
// shift-history model plus hand-computed beat tables.
module tb_skew_feed_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       start, in_valid;
    logic [1:0][7:0]  vec_len;
    logic [1:0][31:0] in_data;
    logic [31:0] od0;
    logic [7:0]  od1;
    logic [3:0]  ov0;
    logic        ov1, ir0, ir1, adv0, adv1, busy0, busy1, done0, done1;
    wire [1:0][31:0] od  = {{24'd0, od1}, od0};
    wire [1:0][3:0]  ov  = {{3'd0, ov1}, ov0};
    wire [1:0]       ir  = {ir1, ir0};
    wire [1:0]       adv = {adv1, adv0};
    wire [1:0]       busy = {busy1, busy0};
    wire [1:0]       done = {done1, done0};

    skew_feed_ctrl #(.ROWS(4), .DATA_WIDTH(8), .LEN_WIDTH(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .vec_len(vec_len[0]),
        .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data[0]),
        .out_data(od0), .out_valid(ov0), .adv(adv0), .busy(busy0), .done(done0)
    );
    skew_feed_ctrl #(.ROWS(1), .DATA_WIDTH(8), .LEN_WIDTH(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .vec_len(vec_len[1]),
        .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data[1][7:0]),
        .out_data(od1), .out_valid(ov1), .adv(adv1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;
    int rows [2] = '{4, 1};

    // Model: each burst is a count of accepts then ROWS-1 zero shifts; every
    // shift appends its stage-0 load to a history, and lane r shows the entry
    // r shifts back.
    int          act [2], len [2], acc [2], nsh [2], obs_acc [2];
    logic        m_adv [2];
    logic [35:0] h [2][$];
    logic [31:0] bd [2][$];
    logic [3:0]  bv [2][$];
    logic        bdn [2][$];

    task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", nm, i, a, e, $time);
        end
    endtask

    function automatic logic [35:0] exp_out(input int i);
        logic [35:0] r;
        r = '0;
        for (int l = 0; l < rows[i]; l++) begin
            int idx;
            idx = h[i].size() - 1 - l;
            if (idx >= 0) begin
                r[8*l +: 8] = h[i][idx][8*l +: 8];
                r[32+l]     = h[i][idx][32+l];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 0; len[i] = 0; acc[i] = 0; nsh[i] = 0; obs_acc[i] = 0;
                m_adv[i] = 1'b0;
                h[i].delete();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic        s;
                logic [35:0] e;
                s = 1'b0;
                e = '0;
                if (ir[i] && in_valid[i]) obs_acc[i]++;
                if (act[i] == 0) begin
                    if (start[i]) begin
                        act[i] = 1; len[i] = int'(vec_len[i]); acc[i] = 0; nsh[i] = 0;
                    end
                end else if (acc[i] < len[i]) begin
                    if (in_valid[i]) begin
                        acc[i]++;
                        s = 1'b1;
                        e = (i == 0) ? {4'hf, in_data[0]} : {4'h1, 24'd0, in_data[1][7:0]};
                    end
                end else if (len[i] != 0 && nsh[i] < len[i] + rows[i] - 1) begin
                    s = 1'b1;
                end else begin
                    act[i] = 0;
                end
                if (s) begin
                    nsh[i]++;
                    h[i].push_back(e);
                end
                m_adv[i] = s;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [35:0] x;
            logic        dn;
            x  = exp_out(i);
            dn = (act[i] != 0) && (acc[i] == len[i]) &&
                 (len[i] == 0 || nsh[i] == len[i] + rows[i] - 1);
            chk("in_ready", i, 64'(ir[i]), 64'((act[i] != 0) && (acc[i] < len[i])));
            chk("busy", i, 64'(busy[i]), 64'(act[i] != 0));
            chk("done", i, 64'(done[i]), 64'(dn));
            chk("adv", i, 64'(adv[i]), 64'(m_adv[i]));
            chk("out_valid", i, 64'(ov[i]), 64'(x[35:32]));
            chk("out_data", i, 64'(od[i]), 64'(x[31:0]));
            if (adv[i]) begin
                bd[i].push_back(od[i]);
                bv[i].push_back(ov[i]);
                bdn[i].push_back(done[i]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vec(input int k);
        return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    endfunction

    task automatic burst(input int i, input int n, input int stall_n, input bit poke);
        int g;
        bd[i].delete(); bv[i].delete(); bdn[i].delete();
        obs_acc[i] = 0;
        start[i] = 1'b1; vec_len[i] = 8'(n);
        tick;
        start[i] = 1'b0; vec_len[i] = 8'hAA;
        for (int k = 0; k < n; k++) begin
            in_data[i] = vec(k); in_valid[i] = 1'b1;
            if (poke && k == 1) begin start[i] = 1'b1; vec_len[i] = 8'd7; end
            g = 0;
            while (!ir[i] && g < 20) begin tick; g++; end
            tick;
            start[i] = 1'b0;
            if (!poke) in_valid[i] = 1'b0;
            if (k == 0 && stall_n > 0) repeat (stall_n) tick;
        end
        g = 0;
        while (!done[i] && g < 40) begin tick; g++; end
        chk("done_seen", i, 64'(done[i]), 64'd1);
        tick;
        in_valid[i] = 1'b0;
    endtask

    // Vector k lane r carries 4k+r+1; lane r is live on beats r..r+n-1.
    task automatic check_beats(input int i, input int n);
        int nb;
        nb = n + rows[i] - 1;
        chk("beat_count", i, 64'(bd[i].size()), 64'(nb));
        for (int b = 0; b < nb && b < bd[i].size(); b++) begin
            logic [31:0] ed;
            logic [3:0]  ev;
            ed = '0; ev = '0;
            for (int r = 0; r < rows[i]; r++) begin
                if (b >= r && b < r + n) begin
                    ev[r] = 1'b1;
                    ed[8*r +: 8] = 8'(4*(b-r) + r + 1);
                end
            end
            chk("beat_valid", b, 64'(bv[i][b]), 64'(ev));
            chk("beat_data", b, 64'(bd[i][b]), 64'(ed));
            chk("beat_done", b, 64'(bdn[i][b]), 64'(b == nb - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0; in_valid = '0; vec_len = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 0, {od0, 28'd0, ov0}, 64'd0);
        chk("rst_ctl", 0, 64'({ir0, adv0, busy0, done0}), 64'd0);
        rst_n = 1'b1;
        tick;

        burst(0, 3, 0, 1'b0);
        check_beats(0, 3);

        burst(0, 3, 2, 1'b0);
        check_beats(0, 3);

        start[0] = 1'b1; vec_len[0] = 8'd0;
        tick;
        start[0] = 1'b0;
        chk("len0_pulse", 0, 64'({busy0, done0, adv0, ir0}), 64'b1100);
        tick;
        chk("len0_after", 0, 64'({busy0, done0, adv0, ir0}), 64'b0000);

        burst(1, 2, 0, 1'b0);
        check_beats(1, 2);

        start[0] = 1'b1; vec_len[0] = 8'd5;
        tick;
        start[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data[0] = vec(k); in_valid[0] = 1'b1;
            tick;
        end
        in_valid[0] = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 0, {od0, 28'd0, ov0}, 64'd0);
        chk("rst_mid_ctl", 0, 64'({ir0, adv0, busy0, done0}), 64'd0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        burst(0, 3, 0, 1'b0);
        check_beats(0, 3);

        burst(0, 3, 0, 1'b1);
        chk("poke_accepts", 0, 64'(obs_acc[0]), 64'd3);
        check_beats(0, 3);

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
